// File: rtl/nand_deser_pkg.sv
// Shared types and helpers for the bit-serial deserialiser.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Optional feature macro used by the design files: PARITY_CHECK_EN.
package nand_deser_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

  // Counter width for a count that runs 0..nb-1; never narrower than one bit.
  function automatic int cnt_w(input int nb);
    int w;
    w = $clog2(nb);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/nand_deser_shreg.sv
// Serial bit collector: shift register, bit counter and parity accumulator.
// Latency: o_word/o_word_done are valid combinationally in the cycle the last bit is presented.
// Backpressure: none; every bit with i_bit_vld=1 is accepted unconditionally.
// Ports: C clock, R sync reset (active-high), i_bit_vld/i_bit_dat serial input,
//        o_word assembled word, o_word_done completion pulse, o_par_ok parity verdict.
// Macro PARITY_CHECK_EN: adds a trailing even-parity bit to every word.
module nand_deser_shreg
  import nand_deser_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int MSB_FIRST = 0
) (
  input  logic             C,
  input  logic             R,
  input  logic             i_bit_vld,
  input  logic             i_bit_dat,
  output logic [WIDTH-1:0] o_word,
  output logic             o_word_done,
  output logic             o_par_ok
);

`ifdef PARITY_CHECK_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int            CW   = cnt_w(NB);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_sh_nxt;
  logic             w_last;

  assign w_last      = (r_cnt == LAST);
  assign o_word_done = i_bit_vld & w_last;

  // MSB-first shifts left so the first bit ends at the top; LSB-first shifts
  // right so the first bit ends at bit 0.
  if (MSB_FIRST != 0) begin : g_msb
    assign w_sh_nxt = {r_sh[WIDTH-2:0], i_bit_dat};
  end else begin : g_lsb
    assign w_sh_nxt = {i_bit_dat, r_sh[WIDTH-1:1]};
  end

  always_ff @(posedge C) begin
    if (R) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (i_bit_vld) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
`ifdef PARITY_CHECK_EN
      // The trailing parity bit is not part of the data word.
      if (!w_last) r_sh <= w_sh_nxt;
`else
      r_sh <= w_sh_nxt;
`endif
    end
  end

`ifdef PARITY_CHECK_EN
  logic r_par;

  always_ff @(posedge C) begin
    if (R) begin
      r_par <= 1'b0;
    end else if (i_bit_vld) begin
      r_par <= w_last ? 1'b0 : (r_par ^ i_bit_dat);
    end
  end

  // Data bits are all in r_sh by the time the parity bit arrives.
  assign o_word   = r_sh;
  assign o_par_ok = (r_par == i_bit_dat);
`else
  // The completing bit is folded in combinationally so the word can be
  // loaded on the same edge that accepts it.
  assign o_word   = w_sh_nxt;
  assign o_par_ok = 1'b1;
`endif

endmodule

// File: rtl/nand_serial_deser.sv
// Bit-serial to parallel deserialiser with a single holding register on a valid/ready port.
// Latency: dout_valid rises the cycle after the edge that accepts the last bit of a word.
// Backpressure: none upstream; a word completing while the holder is full and not drained is dropped and sets overflow.
// Ports: C clock, R sync reset (active-high), sin_valid/sin_data serial input,
//        dout/dout_valid/dout_ready output word port, overflow sticky drop flag,
//        ovf_clr clears overflow, parity_err one-cycle parity failure pulse.
// Macro PARITY_CHECK_EN: words carry a trailing even-parity bit; failing words are discarded.
module nand_serial_deser
  import nand_deser_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int MSB_FIRST = 0
) (
  input  logic             C,
  input  logic             R,
  input  logic             sin_valid,
  input  logic             sin_data,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             parity_err
);

  logic [WIDTH-1:0] w_word;
  logic             w_done;
  logic             w_par_ok;
  logic             w_good;
  logic             w_load;
  logic             w_drop;
  hold_state_t      r_state;
  hold_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_dout;
  logic             r_ovf;

  nand_deser_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .C           (C),
    .R           (R),
    .i_bit_vld   (sin_valid),
    .i_bit_dat   (sin_data),
    .o_word      (w_word),
    .o_word_done (w_done),
    .o_par_ok    (w_par_ok)
  );

  // Only words that pass parity (always true without the check) reach the holder.
  assign w_good = w_done & w_par_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      HOLD_EMPTY: begin
        if (w_good) begin
          w_state_nxt = HOLD_FULL;
          w_load      = 1'b1;
        end
      end
      HOLD_FULL: begin
        if (w_good) begin
          // Drain and refill in one cycle when the consumer takes the old word.
          if (dout_ready) w_load = 1'b1;
          else            w_drop = 1'b1;
        end else if (dout_ready) begin
          w_state_nxt = HOLD_EMPTY;
        end
      end
      default: w_state_nxt = HOLD_EMPTY;
    endcase
  end

  always_ff @(posedge C) begin
    if (R) r_state <= HOLD_EMPTY;
    else   r_state <= w_state_nxt;
  end

  always_ff @(posedge C) begin
    if (R)           r_dout <= '0;
    else if (w_load) r_dout <= w_word;
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge C) begin
    if (R)            r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end

`ifdef PARITY_CHECK_EN
  logic r_par_err;

  always_ff @(posedge C) begin
    if (R) r_par_err <= 1'b0;
    else   r_par_err <= w_done & ~w_par_ok;
  end

  assign parity_err = r_par_err;
`else
  assign parity_err = 1'b0;
`endif

  assign dout       = r_dout;
  assign dout_valid = (r_state == HOLD_FULL);
  assign overflow   = r_ovf;

endmodule
